// File: rtl/bip_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bip_pkg
// Purpose  : Shared BIP definitions: opcode values, opcode width and the
//            encoding of the program-memory loader state machine.
// Revision : 1.0 - initial release
// ============================================================================
package bip_pkg;

  localparam int OPCODE_BITS = 5;

  // Instruction opcodes (upper OPCODE_BITS of an instruction word)
  localparam logic [OPCODE_BITS-1:0] HLT  = 5'd0;
  localparam logic [OPCODE_BITS-1:0] STO  = 5'd1;
  localparam logic [OPCODE_BITS-1:0] LD   = 5'd2;
  localparam logic [OPCODE_BITS-1:0] LDI  = 5'd3;
  localparam logic [OPCODE_BITS-1:0] ADD  = 5'd4;
  localparam logic [OPCODE_BITS-1:0] ADDI = 5'd5;
  localparam logic [OPCODE_BITS-1:0] SUB  = 5'd6;
  localparam logic [OPCODE_BITS-1:0] SUBI = 5'd7;

  // Program memory operating state
  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage : bip_pkg
`default_nettype wire

// File: rtl/program_memory_loadable_if.sv
`default_nettype none
// ============================================================================
// Module   : program_memory_loadable_if
// Purpose  : Bundles the loader write stream, the fetch port and the status
//            outputs of the loadable program memory.
// Ports    : master - loader/CPU side (drives i_*, observes o_*)
//            slave  - program memory side (observes i_*, drives o_*)
// Revision : 1.0 - initial release
// ============================================================================
interface program_memory_loadable_if #(
  parameter int ADDRESS_BITS = 11,
  parameter int DATA_BITS    = 16
);

  // Loader stream
  logic                    i_wr_valid;
  logic [DATA_BITS-1:0]    i_wr_data;
  logic                    o_wr_ready;
  logic                    i_load_done;
  logic                    i_reload;

  // Fetch port
  logic                    i_rd_en;
  logic [ADDRESS_BITS-1:0] i_address;
  logic [DATA_BITS-1:0]    o_data;
  logic                    o_data_valid;

  // Status
  logic                    o_run;
  logic [ADDRESS_BITS:0]   o_word_count;
  logic                    o_overflow;

  modport master (
    output i_wr_valid, i_wr_data, i_load_done, i_reload, i_rd_en, i_address,
    input  o_wr_ready, o_data, o_data_valid, o_run, o_word_count, o_overflow
  );

  modport slave (
    input  i_wr_valid, i_wr_data, i_load_done, i_reload, i_rd_en, i_address,
    output o_wr_ready, o_data, o_data_valid, o_run, o_word_count, o_overflow
  );

endinterface : program_memory_loadable_if
`default_nettype wire

// File: rtl/bip_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module   : bip_sdp_ram
// Purpose  : Simple dual-port RAM, one write port and one registered read
//            port, no reset (contents survive rst).
// Ports    : clk                       - clock
//            i_wr_en/i_wr_addr/i_wr_data - write port
//            i_rd_en/i_rd_addr         - read request
//            o_rd_data                 - read data, updated only on i_rd_en
// Revision : 1.0 - initial release
// ============================================================================
module bip_sdp_ram #(
  parameter int ADDRESS_BITS = 11,
  parameter int DATA_BITS    = 16,
  parameter int MEM_DEPTH    = 2**ADDRESS_BITS
) (
  input  wire logic                    clk,
  input  wire logic                    i_wr_en,
  input  wire logic [ADDRESS_BITS-1:0] i_wr_addr,
  input  wire logic [DATA_BITS-1:0]    i_wr_data,
  input  wire logic                    i_rd_en,
  input  wire logic [ADDRESS_BITS-1:0] i_rd_addr,
  output logic      [DATA_BITS-1:0]    o_rd_data
);

  logic [DATA_BITS-1:0] r_mem [MEM_DEPTH];
  logic [DATA_BITS-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register holds its value when no read is requested
  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule : bip_sdp_ram
`default_nettype wire

// File: rtl/program_memory_loadable.sv
`default_nettype none
// ============================================================================
// Module   : program_memory_loadable
// Purpose  : Run-time loadable BIP program memory. Words stream in through
//            the loader port while in LOAD; in RUN the CPU fetches through a
//            registered, one-cycle-latency port. Fetches at or beyond the
//            loaded word count return FILL_WORD.
// Ports    : clk - clock, rst - asynchronous active-high reset
//            bus - program_memory_loadable_if.slave (loader, fetch, status)
// Revision : 1.0 - initial release
// ============================================================================
module program_memory_loadable
  import bip_pkg::*;
#(
  parameter int                   ADDRESS_BITS = 11,
  parameter int                   DATA_BITS    = 16,
  parameter int                   MEM_DEPTH    = 2**ADDRESS_BITS,
  parameter logic [DATA_BITS-1:0] FILL_WORD    = '0
) (
  input wire logic                clk,
  input wire logic                rst,
  program_memory_loadable_if.slave bus
);

  // RAM index width: just enough to address MEM_DEPTH words
  localparam int                    c_idx_bits = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDRESS_BITS:0] c_depth    = (ADDRESS_BITS+1)'(MEM_DEPTH);
  localparam logic [ADDRESS_BITS:0] c_last     = c_depth - 1'b1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDRESS_BITS:0] r_count;      // doubles as the write pointer
  logic                  r_valid;
  logic                  r_use_ram;    // o_data comes from RAM (else FILL_WORD)
  logic                  r_overflow;

  logic                  w_wr_ready;
  logic                  w_wr_fire;
  logic                  w_last_word;
  logic                  w_fetch;
  logic                  w_in_range;
  logic [DATA_BITS-1:0]  w_ram_q;

  // --------------------------------------------------------------------------
  // Handshake decode. i_reload suppresses any write or fetch in its cycle.
  // --------------------------------------------------------------------------
  assign w_wr_ready  = (r_state == ST_LOAD) && (r_count < c_depth);
  assign w_wr_fire   = bus.i_wr_valid && w_wr_ready && !bus.i_reload;
  assign w_last_word = w_wr_fire && (r_count == c_last);
  assign w_fetch     = (r_state == ST_RUN) && bus.i_rd_en && !bus.i_reload;
  assign w_in_range  = {1'b0, bus.i_address} < r_count;

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.i_reload) begin
      w_state_nxt = ST_LOAD;
    end else begin
      case (r_state)
        // A word written together with load_done lands before entering RUN;
        // filling the last slot finishes the load automatically.
        ST_LOAD: if (bus.i_load_done || w_last_word) w_state_nxt = ST_RUN;
        ST_RUN:  w_state_nxt = ST_RUN;
        default: w_state_nxt = ST_LOAD;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Word count, fetch flags and sticky overflow
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_use_ram  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (bus.i_reload) begin
        r_count <= '0;
      end else if (w_wr_fire) begin
        r_count <= r_count + 1'b1;
      end

      r_valid <= w_fetch;

      // Out-of-range fetches select FILL_WORD; no fetch keeps the selection,
      // and the RAM read register holds too, so o_data holds.
      if (bus.i_reload) begin
        r_use_ram <= 1'b0;
      end else if (w_fetch) begin
        r_use_ram <= w_in_range;
      end

      if (bus.i_wr_valid && !w_wr_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  bip_sdp_ram #(
    .ADDRESS_BITS (c_idx_bits),
    .DATA_BITS    (DATA_BITS),
    .MEM_DEPTH    (MEM_DEPTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_fire),
    .i_wr_addr (r_count[c_idx_bits-1:0]),
    .i_wr_data (bus.i_wr_data),
    .i_rd_en   (w_fetch && w_in_range),
    .i_rd_addr (bus.i_address[c_idx_bits-1:0]),
    .o_rd_data (w_ram_q)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.o_wr_ready   = w_wr_ready;
  assign bus.o_data       = r_use_ram ? w_ram_q : FILL_WORD;
  assign bus.o_data_valid = r_valid;
  assign bus.o_run        = (r_state == ST_RUN);
  assign bus.o_word_count = r_count;
  assign bus.o_overflow   = r_overflow;

endmodule : program_memory_loadable
`default_nettype wire

// File: tb/tb_program_memory_loadable.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_memory_loadable
// Purpose  : Directed, table-driven bench for program_memory_loadable with a
//            4-word memory, plus hand-written asynchronous reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_memory_loadable;

  localparam int AB = 11;
  localparam int DB = 16;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  program_memory_loadable_if #(.ADDRESS_BITS(AB), .DATA_BITS(DB)) bus ();

  program_memory_loadable #(
    .ADDRESS_BITS (AB),
    .DATA_BITS    (DB),
    .MEM_DEPTH    (4),
    .FILL_WORD    (16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of inputs and the outputs expected after the following edge
  typedef struct {
    int wv; int wd; int ld; int rl; int re; int ad;
    int xd; int xv; int xr; int xc; int xo; int xy;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic check_all(input string p, input int xd, input int xv, input int xr,
                           input int xc, input int xo, input int xy);
    check({p, "_data"},  32'(bus.o_data),       xd);
    check({p, "_valid"}, 32'(bus.o_data_valid), xv);
    check({p, "_run"},   32'(bus.o_run),        xr);
    check({p, "_count"}, 32'(bus.o_word_count), xc);
    check({p, "_ovf"},   32'(bus.o_overflow),   xo);
    check({p, "_ready"}, 32'(bus.o_wr_ready),   xy);
  endtask

  task automatic drive(input int wv, input int wd, input int ld, input int rl,
                       input int re, input int ad);
    bus.i_wr_valid  = 1'(wv);
    bus.i_wr_data   = 16'(wd);
    bus.i_load_done = 1'(ld);
    bus.i_reload    = 1'(rl);
    bus.i_rd_en     = 1'(re);
    bus.i_address   = 11'(ad);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    //            wv  wd       ld rl re ad   xd       xv xr xc xo xy
    vecs[0]  = '{1, 'h1FFC, 0, 0, 0, 0,  'h0000, 0, 0, 1, 0, 1};
    vecs[1]  = '{1, 'h0801, 0, 0, 0, 0,  'h0000, 0, 0, 2, 0, 1};
    vecs[2]  = '{1, 'h0000, 1, 0, 0, 0,  'h0000, 0, 1, 3, 0, 0};
    vecs[3]  = '{0, 0,      0, 0, 1, 2,  'h0000, 1, 1, 3, 0, 0};
    vecs[4]  = '{0, 0,      0, 0, 1, 0,  'h1FFC, 1, 1, 3, 0, 0};
    vecs[5]  = '{0, 0,      0, 0, 0, 0,  'h1FFC, 0, 1, 3, 0, 0};
    vecs[6]  = '{0, 0,      0, 0, 1, 1,  'h0801, 1, 1, 3, 0, 0};
    vecs[7]  = '{0, 0,      0, 0, 1, 5,  'h0000, 1, 1, 3, 0, 0};
    vecs[8]  = '{0, 0,      1, 0, 1, 0,  'h1FFC, 1, 1, 3, 0, 0};
    vecs[9]  = '{0, 0,      0, 1, 1, 0,  'h0000, 0, 0, 0, 0, 1};
    vecs[10] = '{0, 0,      0, 0, 1, 0,  'h0000, 0, 0, 0, 0, 1};
    vecs[11] = '{1, 'h2807, 1, 0, 0, 0,  'h0000, 0, 1, 1, 0, 0};
    vecs[12] = '{0, 0,      0, 0, 1, 0,  'h2807, 1, 1, 1, 0, 0};
    vecs[13] = '{0, 0,      0, 0, 1, 1,  'h0000, 1, 1, 1, 0, 0};
    vecs[14] = '{0, 0,      0, 1, 0, 0,  'h0000, 0, 0, 0, 0, 1};
    vecs[15] = '{1, 'hA001, 0, 0, 0, 0,  'h0000, 0, 0, 1, 0, 1};
    vecs[16] = '{1, 'hA002, 0, 0, 0, 0,  'h0000, 0, 0, 2, 0, 1};
    vecs[17] = '{1, 'hA003, 0, 0, 0, 0,  'h0000, 0, 0, 3, 0, 1};
    vecs[18] = '{1, 'hA004, 0, 0, 0, 0,  'h0000, 0, 1, 4, 0, 0};
    vecs[19] = '{1, 'hA005, 0, 0, 0, 0,  'h0000, 0, 1, 4, 1, 0};
    vecs[20] = '{1, 'hA006, 0, 0, 0, 0,  'h0000, 0, 1, 4, 1, 0};
    vecs[21] = '{0, 0,      0, 0, 1, 3,  'hA004, 1, 1, 4, 1, 0};
    vecs[22] = '{0, 0,      0, 0, 1, 0,  'hA001, 1, 1, 4, 1, 0};
    vecs[23] = '{1, 'hA007, 0, 1, 1, 0,  'h0000, 0, 0, 0, 1, 1};
    vecs[24] = '{1, 'h3832, 1, 0, 0, 0,  'h0000, 0, 1, 1, 1, 0};
    vecs[25] = '{0, 0,      0, 0, 1, 0,  'h3832, 1, 1, 1, 1, 0};

    // Reset state
    tick();
    tick();
    check_all("reset", 'h0000, 0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Table: load/fetch, masking, reload, auto-finish and overflow
    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].wv, vecs[i].wd, vecs[i].ld, vecs[i].rl, vecs[i].re, vecs[i].ad);
      tick();
      check_all($sformatf("v%0d", i), vecs[i].xd, vecs[i].xv, vecs[i].xr,
                vecs[i].xc, vecs[i].xo, vecs[i].xy);
    end
    drive(0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-fetch: outputs clear before the next edge
    #3;
    rst = 1'b1;
    #1;
    check_all("arst_fetch", 'h0000, 0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Asynchronous reset mid-load after two words
    drive(1, 'h1111, 0, 0, 0, 0);
    tick();
    drive(1, 'h2222, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("mid_load_count", 32'(bus.o_word_count), 2);
    #3;
    rst = 1'b1;
    #1;
    check_all("arst_load", 'h0000, 0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Fresh load restarts at address 0; the stale word at address 1 is masked
    drive(1, 'h1234, 1, 0, 0, 0);
    tick();
    check_all("reload_w0", 'h0000, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    tick();
    check_all("reload_rd0", 'h1234, 1, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 1);
    tick();
    check_all("reload_rd1", 'h0000, 1, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("idle_valid", 32'(bus.o_data_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_program_memory_loadable
`default_nettype wire

// File: doc/program_memory_loadable.md
Name: program_memory_loadable

Overview:
Successor to the BIP instruction store. Provides a parametrised synchronous program memory whose contents come in at run time through a streaming write port (bootloader, UART, or test harness), not from a fixed reset image. The CPU fetch path reads through a registered port gated by a run state. It sits between the loader front-end and the BIP fetch stage.

Parameters:
ADDRESS_BITS, 11, fetch/write address width
DATA_BITS, 16, instruction word width (opcode 5 bits + operand ADDRESS_BITS)
MEM_DEPTH, 2**ADDRESS_BITS, number of words; must satisfy 1 <= MEM_DEPTH <= 2**ADDRESS_BITS
FILL_WORD, 0, word returned for unloaded or out-of-range fetches (0 = HLT)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
i_wr_valid  in  1  loader word present
i_wr_data  in  DATA_BITS  loader word
o_wr_ready  out  1  block accepts a loader word this cycle
i_load_done  in  1  loader signals end of program
i_reload  in  1  one-cycle request to return to LOAD and discard the program
i_rd_en  in  1  fetch request
i_address  in  ADDRESS_BITS  fetch address
o_data  out  DATA_BITS  fetched word (registered)
o_data_valid  out  1  o_data holds the result of the previous cycle's accepted fetch
o_run  out  1  block in RUN state
o_word_count  out  ADDRESS_BITS+1  number of words loaded
o_overflow  out  1  sticky: a write was offered while o_wr_ready=0

Behaviour:
- Reset (async assert, sync release): state=LOAD, write pointer=0, o_word_count=0, o_data=FILL_WORD, o_data_valid=0, o_run=0, o_overflow=0. RAM contents are not cleared; stale words are masked by o_word_count.
- States: LOAD, RUN.
- LOAD: o_wr_ready=1 while o_word_count < MEM_DEPTH. A write occurs when i_wr_valid&&o_wr_ready: mem[ptr]<=i_wr_data, ptr++, count++.
- LOAD->RUN: on i_load_done, or on the cycle count reaches MEM_DEPTH (auto-finish). If i_wr_valid and i_load_done are both high while ready, the word is written first and the state then enters RUN in the same edge.
- In LOAD, i_rd_en is ignored: o_data_valid=0 and o_data holds its value.
- RUN: o_run=1, o_wr_ready=0. A fetch with i_rd_en=1 gives o_data at the next edge and o_data_valid=1 for that one cycle (latency 1). o_data = mem[i_address] if i_address < o_word_count, else FILL_WORD. If i_rd_en=0, o_data holds and o_data_valid=0.
- i_wr_valid while o_wr_ready=0 (RUN, or LOAD full) sets o_overflow. The write is dropped. Only rst clears o_overflow.
- i_reload (any state): next state is LOAD, ptr=0, count=0, o_data=FILL_WORD, o_data_valid=0. i_reload takes priority over a simultaneous fetch, write, or load_done. o_overflow is preserved.
- i_load_done in RUN is ignored.
- Pointer does not wrap; writes stop at MEM_DEPTH.
- Async rst mid-load or mid-fetch returns all outputs to reset values immediately.

Decomposition:
- Shared package bip_pkg: opcode localparams (HLT=0, STO=1, LD=2, LDI=3, ADD=4, ADDI=5, SUB=6, SUBI=7), OPCODE_BITS=5, state encoding LOAD/RUN.
- Sub-module bip_sdp_ram: simple dual-port RAM (one write port, one registered read port), no reset, parametrised by ADDRESS_BITS/DATA_BITS/MEM_DEPTH. This module adds the FSM, counters, masking and valid flags.

Test Plan:
- Load 3 words {LDI,-4}=0x1FFC, {STO,1}=0x0801, 0x0000 with i_load_done on the 3rd -> o_word_count=3, o_run=1 next cycle. Fetches of addresses 0,1,2 return 0x1FFC, 0x0801, 0x0000, each with o_data_valid one cycle after i_rd_en.
- After that load, fetch address 5 -> o_data=FILL_WORD (0x0000), o_data_valid=1. Fetch during LOAD -> o_data_valid stays 0.
- MEM_DEPTH=4: stream 6 words without i_load_done -> count=4, auto RUN after 4th write, o_wr_ready=0, o_overflow=1 on the 5th offered word. mem[3] keeps the 4th word.
- In RUN, assert i_reload with i_rd_en=1 -> o_data_valid=0, o_data=0x0000, count=0, o_run=0, o_overflow unchanged. Reload 1 word 0x2807 -> address 0 reads 0x2807 and address 1 reads 0x0000 (the stale word is masked).
- Assert rst asynchronously between clock edges mid-load after 2 words -> outputs reset before the next edge, count=0. After release, a new load starts at address 0.
- Same-cycle i_wr_valid+i_load_done with word 0x3832 as the 1st word -> count=1, RUN next cycle, address 0 reads 0x3832.
